// File: rtl/instr_inv_queue_if.sv
// Bundle for the invalidation queue: store-commit request side, the two
// invalidation consumers (icache, branch predictor) and occupancy status.
//
// Handshake rule for every valid/ready pair in this bundle: a transfer
// happens on a rising clk edge where valid and ready are both high; a source
// holds valid and its payload stable until that transfer, and ready may be
// high or low independently of valid.
interface instr_inv_queue_if #(
  parameter int LA_W  = 28,
  parameter int CNT_W = 3
);
  logic              inv_valid;
  logic [31:0]       inv_addr;
  logic              inv_ready;
  logic              ic_inv_valid;
  logic [LA_W-1:0]   ic_inv_line;
  logic              ic_inv_ready;
  logic              bp_inv_valid;
  logic [LA_W-1:0]   bp_inv_line;
  logic              bp_inv_ready;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  // Environment side: store commit plus both consumers.
  modport master (
    output inv_valid, inv_addr, ic_inv_ready, bp_inv_ready,
    input  inv_ready, ic_inv_valid, ic_inv_line, bp_inv_valid, bp_inv_line,
    input  count, empty, full
  );

  // Queue side.
  modport slave (
    input  inv_valid, inv_addr, ic_inv_ready, bp_inv_ready,
    output inv_ready, ic_inv_valid, ic_inv_line, bp_inv_valid, bp_inv_line,
    output count, empty, full
  );
endinterface

// File: rtl/instr_inv_queue.sv
// Instruction-coherency invalidation queue. Committed store addresses are
// range-filtered, reduced to line addresses, coalesced against the newest
// entry when that entry has not yet been seen by a consumer, and issued from
// the head to both the icache and the branch predictor. The head is popped
// once both consumers have taken it. empty lets fence.i wait for drain.
module instr_inv_queue #(
  parameter int          DEPTH  = 4,
  parameter int          LINE_W = 4,
  parameter logic [31:0] ADDR_L = 32'h8000_0000,
  parameter logic [31:0] ADDR_H = 32'h8FFF_FFFF
) (
  input logic              clk,
  input logic              rst,
  instr_inv_queue_if.slave q_if
);
  localparam int LA_W  = 30 - $clog2(LINE_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W-1:0] tail_last;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ic_done_q, bp_done_q;

  logic [LA_W-1:0]  line_in;
  logic             in_range, empty_w, full_w;
  logic             ic_fire, bp_fire, pop;
  logic             fire, tail_match, tail_seen, coalesce_hit, push;

  assign line_in   = q_if.inv_addr[31:32-LA_W];
  assign in_range  = (q_if.inv_addr >= ADDR_L) && (q_if.inv_addr <= ADDR_H);
  assign empty_w   = (count_q == '0);
  assign full_w    = (count_q == CNT_W'(DEPTH));
  assign tail_last = tail_q - PTR_W'(1);

  // Head issue: each consumer is offered the head until it has taken it.
  assign q_if.ic_inv_valid = !empty_w && !ic_done_q;
  assign q_if.bp_inv_valid = !empty_w && !bp_done_q;
  assign q_if.ic_inv_line  = mem_q[head_q];
  assign q_if.bp_inv_line  = mem_q[head_q];
  assign ic_fire = q_if.ic_inv_valid && q_if.ic_inv_ready;
  assign bp_fire = q_if.bp_inv_valid && q_if.bp_inv_ready;
  assign pop     = (ic_done_q || ic_fire) && (bp_done_q || bp_fire);

  // The tail is only exposed to consumers when it is also the head, so a
  // merge is blocked only for a single-entry queue that has been (or is
  // being) handed to either consumer.
  assign tail_match   = (mem_q[tail_last] == line_in);
  assign tail_seen    = (count_q == CNT_W'(1)) &&
                        (ic_done_q || bp_done_q || ic_fire || bp_fire);
  assign coalesce_hit = in_range && !empty_w && tail_match && !tail_seen;

  // When full the queue holds >= 2 entries, so the tail is never the head
  // and a merge reduces to a plain line match. Writing it this way keeps
  // consumer readies out of the inv_ready cone entirely.
  assign q_if.inv_ready = !full_w || !in_range || tail_match;

  assign fire = q_if.inv_valid && q_if.inv_ready;
  assign push = fire && in_range && !coalesce_hit;

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  assign q_if.count = count_q;
  assign q_if.empty = empty_w;
  assign q_if.full  = full_w;

  // Queue storage, pointers, occupancy and per-head consumer done bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ic_done_q <= 1'b0;
      bp_done_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= line_in;
        tail_q        <= tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_q    <= head_q + PTR_W'(1);
        ic_done_q <= 1'b0;
        bp_done_q <= 1'b0;
      end else begin
        ic_done_q <= ic_done_q || ic_fire;
        bp_done_q <= bp_done_q || bp_fire;
      end
      count_q <= count_d;
    end
  end

  // A push into a full queue would overwrite the head.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full_w));
endmodule

// File: tb/tb_instr_inv_queue.sv
// Bench for instr_inv_queue: directed scenarios then random traffic. A
// reference model (list of queued lines plus per-consumer expected-line
// queues) is updated from observed handshakes; a monitor compares all
// outputs every cycle on the falling edge.
module tb_instr_inv_queue;
  localparam int DEPTH  = 4;
  localparam int LINE_W = 4;
  localparam int LA_W   = 28;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_inv_queue_if #(.LA_W(LA_W), .CNT_W(CNT_W)) bus ();

  instr_inv_queue #(
    .DEPTH(DEPTH), .LINE_W(LINE_W),
    .ADDR_L(32'h8000_0000), .ADDR_H(32'h8FFF_FFFF)
  ) dut (
    .clk(clk), .rst(rst), .q_if(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: lines resident in the queue, and for each consumer the
  // lines it still has to receive, in order.
  logic [LA_W-1:0] mq[$];
  logic [LA_W-1:0] ic_exp_q[$];
  logic [LA_W-1:0] bp_exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LA_W-1:0] line_of(input logic [31:0] a);
    return a[31:32-LA_W];
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a <= 32'h8FFF_FFFF);
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_empty"}, 32'(bus.empty), 1);
    chk({tag, "_full"}, 32'(bus.full), 0);
    chk({tag, "_count"}, 32'(bus.count), 0);
    chk({tag, "_ic_valid"}, 32'(bus.ic_inv_valid), 0);
    chk({tag, "_bp_valid"}, 32'(bus.bp_inv_valid), 0);
    chk({tag, "_inv_ready"}, 32'(bus.inv_ready), 1);
  endtask

  // Monitor / scoreboard.
  int n;
  bit ic_seen, bp_seen, exp_icv, exp_bpv, ic_fire, bp_fire, ir, coal, exp_rdy;
  logic [LA_W-1:0] wl;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        ic_exp_q.delete();
        bp_exp_q.delete();
        chk_reset_outs("rst_hold");
      end else begin
        n = mq.size();
        chk("count", 32'(bus.count), 32'(n));
        chk("empty", 32'(bus.empty), 32'(n == 0));
        chk("full", 32'(bus.full), 32'(n == DEPTH));
        ic_seen = (ic_exp_q.size() < n);
        bp_seen = (bp_exp_q.size() < n);
        exp_icv = (n > 0) && !ic_seen;
        exp_bpv = (n > 0) && !bp_seen;
        chk("ic_valid", 32'(bus.ic_inv_valid), 32'(exp_icv));
        chk("bp_valid", 32'(bus.bp_inv_valid), 32'(exp_bpv));
        if (exp_icv && ic_exp_q.size() > 0) chk("ic_line", 32'(bus.ic_inv_line), 32'(ic_exp_q[0]));
        if (exp_bpv && bp_exp_q.size() > 0) chk("bp_line", 32'(bus.bp_inv_line), 32'(bp_exp_q[0]));
        ic_fire = exp_icv && bus.ic_inv_ready;
        bp_fire = exp_bpv && bus.bp_inv_ready;

        coal = 1'b0;
        exp_rdy = 1'b1;
        ir = in_rng(bus.inv_addr);
        wl = line_of(bus.inv_addr);
        if (bus.inv_valid) begin
          // Merge only into a newest entry no consumer has touched.
          coal = ir && (n > 0) && (mq[n-1] == wl) &&
                 !((n == 1) && (ic_seen || bp_seen || ic_fire || bp_fire));
          exp_rdy = (n < DEPTH) || !ir || coal;
          chk("inv_ready", 32'(bus.inv_ready), 32'(exp_rdy));
        end

        if (ic_fire) void'(ic_exp_q.pop_front());
        if (bp_fire) void'(bp_exp_q.pop_front());
        if (n > 0 && ic_exp_q.size() < n && bp_exp_q.size() < n) void'(mq.pop_front());

        if (bus.inv_valid && exp_rdy && ir && !coal) begin
          mq.push_back(wl);
          ic_exp_q.push_back(wl);
          bp_exp_q.push_back(wl);
        end
      end
    end
  end

  // Driver: one call = one clock cycle of inputs, applied just after the edge.
  task automatic cyc(input logic v, input logic [31:0] a, input logic icr, input logic bpr);
    @(posedge clk);
    #1;
    bus.inv_valid    = v;
    bus.inv_addr     = a;
    bus.ic_inv_ready = icr;
    bus.bp_inv_ready = bpr;
  endtask

  task automatic idle(input int k, input logic icr, input logic bpr);
    for (int i = 0; i < k; i++) cyc(1'b0, 32'h0, icr, bpr);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return 32'h6000_0000 | 32'($urandom_range(0, 255));
      1: return 32'h7FFF_FFFF;
      2: return 32'h9000_0000;
      3: return 32'h8FFF_FFFF;
      4: return 32'h8000_0000;
      default: return 32'h8000_0000 + 32'($urandom_range(0, 5) * 16) + 32'($urandom_range(0, 15));
    endcase
  endfunction

  int thr_v, thr_ic, thr_bp;
  int waited;

  initial begin
    rst = 1'b1;
    bus.inv_valid = 1'b0;
    bus.inv_addr = 32'h0;
    bus.ic_inv_ready = 1'b0;
    bus.bp_inv_ready = 1'b0;
    #2 chk_reset_outs("por");
    idle(3, 1'b0, 1'b0);
    rst = 1'b0;

    // Single write, staggered consumers.
    cyc(1'b1, 32'h8000_0010, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(2, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b1);
    idle(2, 1'b0, 1'b0);

    // Out-of-range writes on both sides of the window.
    cyc(1'b1, 32'h6000_0000, 1'b0, 1'b0);
    cyc(1'b1, 32'h9000_0000, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);

    // Coalescing with consumers stalled.
    cyc(1'b1, 32'h8000_0004, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_000C, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0020, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    cyc(1'b1, 32'h8000_0020, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    idle(8, 1'b1, 1'b1);

    // Fill to full, then try in-range and out-of-range writes, then drain.
    cyc(1'b1, 32'h8000_0100, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0110, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0120, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0130, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0140, 1'b0, 1'b0);
    cyc(1'b1, 32'h7000_0000, 1'b0, 1'b0);
    idle(7, 1'b1, 1'b1);

    // Simultaneous push and pop at count=2 across the pointer wrap.
    cyc(1'b1, 32'h8000_0200, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0210, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0220, 1'b1, 1'b1);
    cyc(1'b1, 32'h8000_0230, 1'b1, 1'b1);
    idle(5, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle with count=3 and the head taken by icache.
    cyc(1'b1, 32'h8000_0300, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0310, 1'b0, 1'b0);
    cyc(1'b1, 32'h8000_0320, 1'b0, 1'b0);
    idle(1, 1'b1, 1'b0);
    idle(1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_reset_outs("async_rst");
    idle(1, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 32'h8000_0400, 1'b0, 1'b0);
    idle(4, 1'b1, 1'b1);

    // Random traffic with varying pressure on each side.
    for (int blk = 0; blk < 15; blk++) begin
      thr_v  = $urandom_range(20, 90);
      thr_ic = $urandom_range(5, 100);
      thr_bp = $urandom_range(5, 100);
      for (int i = 0; i < 100; i++)
        cyc($urandom_range(1, 100) <= thr_v, rand_addr(),
            $urandom_range(1, 100) <= thr_ic, $urandom_range(1, 100) <= thr_bp);
    end

    // Drain with a bounded wait.
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    waited = 0;
    while (!bus.empty && waited < 50) begin
      idle(1, 1'b1, 1'b1);
      waited++;
    end
    idle(2, 1'b1, 1'b1);
    chk("drain_empty", 32'(bus.empty), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
